alu_exec_sequencer: RTL and testbench

//  Multi-cycle execute-stage controller for the RV32I integer path. Accepts one decoded instruction
//  per valid/ready handshake, selects ALU operands (RS1/PC/zero vs RS2/IMM/U-IMM), computes the

---
 rtl/alu_seq_pkg.sv | 65 ++++++
 rtl/alu_seq_operands.sv | 76 +++++++
 rtl/alu_exec_sequencer.sv | 147 ++++++++++++++
 tb/tb_alu_exec_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Purpose : shared opcode/funct3 encodings, FSM states, ALU op codes and helpers
//           for the RV32I execute-stage sequencer.
// Latency : n/a (declarations and pure functions only).
// Backpressure: n/a.
package alu_seq_pkg;

  // RV32I major opcodes handled by the sequencer
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // FUNCT3 encodings for OP / OP-IMM
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_AND  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_t;

  function automatic logic [31:0] signExtend_12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

  // Single-cycle ops only; shifts are sequenced by the FSM and never reach here.
  function automatic logic [31:0] alu_eval(input alu_op_t op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      ALU_XOR:  r = a ^ b;
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_operands.sv
// Purpose : combinational decode of opcode/funct3/funct7[5] into operand A/B,
//           shift amount, ALU op, shift flag and illegal flag.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
// Ports   : opcode/funct3/funct7_5 + rs1/rs2/pc/imm12/u_imm20 in;
//           opa, opb, shamt, alu_op, is_shift, illegal out.
module alu_seq_operands
  import alu_seq_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] pc,
  input  logic [11:0] imm12,
  input  logic [19:0] u_imm20,
  output logic [31:0] opa,
  output logic [31:0] opb,
  output logic [4:0]  shamt,
  output alu_op_t     alu_op,
  output logic        is_shift,
  output logic        illegal
);

  logic is_reg_op;

  always_comb begin
    opa       = '0;
    opb       = '0;
    shamt     = '0;
    alu_op    = ALU_ADD;
    is_shift  = 1'b0;
    illegal   = 1'b0;
    is_reg_op = (opcode == OPC_OP);

    case (opcode)
      OPC_OP_IMM, OPC_OP: begin
        opa   = rs1_data;
        opb   = is_reg_op ? rs2_data : signExtend_12(imm12);
        shamt = is_reg_op ? rs2_data[4:0] : imm12[4:0];
        case (funct3)
          // SUB exists only in the register form; ADDI ignores funct7[5]
          F3_ADD_SUB: alu_op = (is_reg_op && funct7_5) ? ALU_SUB : ALU_ADD;
          F3_SLT:     alu_op = ALU_SLT;
          F3_SLTU:    alu_op = ALU_SLTU;
          F3_XOR:     alu_op = ALU_XOR;
          F3_OR:      alu_op = ALU_OR;
          F3_AND:     alu_op = ALU_AND;
          F3_SLL: begin
            alu_op   = ALU_SLL;
            is_shift = 1'b1;
          end
          F3_SRL_SRA: begin
            alu_op   = funct7_5 ? ALU_SRA : ALU_SRL;
            is_shift = 1'b1;
          end
          default: alu_op = ALU_ADD;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        opa = rs1_data;
        opb = signExtend_12(imm12);
      end
      OPC_LUI: begin
        opb = {u_imm20, 12'b0};
      end
      OPC_AUIPC: begin
        opa = pc;
        opb = {u_imm20, 12'b0};
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_sequencer.sv
// Purpose : RV32I execute-stage sequencer; one instruction per IN_VALID/IN_READY
//           handshake, result held for writeback until OUT_READY.
// Latency : 1 cycle non-shift; 1+ceil(shamt/SHIFT_STEP) cycles for shifts.
// Backpressure: IN_READY only in IDLE; OUT_VALID/RESULT/ILLEGAL held until OUT_READY.
// Ports   : CLK, RST (async, active-high); IN_VALID/IN_READY + OPCODE, FUNCT3,
//           FUNCT7_5, RS1_DATA, RS2_DATA, PC, IMM12, U_IMM20 in;
//           OUT_VALID/OUT_READY, RESULT, ILLEGAL, BUSY out.
module alu_exec_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [6:0]  OPCODE,
  input  logic [2:0]  FUNCT3,
  input  logic        FUNCT7_5,
  input  logic [31:0] RS1_DATA,
  input  logic [31:0] RS2_DATA,
  input  logic [31:0] PC,
  input  logic [11:0] IMM12,
  input  logic [19:0] U_IMM20,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] RESULT,
  output logic        ILLEGAL,
  output logic        BUSY
);

  localparam logic [4:0] STEP5 = 5'(SHIFT_STEP);

  logic [31:0] opa, opb;
  logic [4:0]  shamt;
  alu_op_t     alu_op;
  logic        is_shift, illegal;

  alu_seq_operands u_operands (
    .opcode   (OPCODE),
    .funct3   (FUNCT3),
    .funct7_5 (FUNCT7_5),
    .rs1_data (RS1_DATA),
    .rs2_data (RS2_DATA),
    .pc       (PC),
    .imm12    (IMM12),
    .u_imm20  (U_IMM20),
    .opa      (opa),
    .opb      (opb),
    .shamt    (shamt),
    .alu_op   (alu_op),
    .is_shift (is_shift),
    .illegal  (illegal)
  );

  state_t      state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        illegal_q, illegal_d;
  logic [31:0] shreg_q, shreg_d;
  logic [4:0]  rem_q, rem_d;
  alu_op_t     shop_q, shop_d;

  logic [4:0]  step;
  logic [31:0] shifted;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    shreg_d   = shreg_q;
    rem_d     = rem_q;
    shop_d    = shop_q;

    // Last step may be shorter than SHIFT_STEP so the total equals shamt exactly
    step = (rem_q < STEP5) ? rem_q : STEP5;
    case (shop_q)
      ALU_SLL: shifted = shreg_q << step;
      ALU_SRA: shifted = $unsigned($signed(shreg_q) >>> step);
      default: shifted = shreg_q >> step;
    endcase

    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          state_d = S_DONE;
          if (illegal) begin
            result_d  = '0;
            illegal_d = 1'b1;
          end else if (is_shift && shamt != 5'd0) begin
            shreg_d = opa;
            rem_d   = shamt;
            shop_d  = alu_op;
            state_d = S_SHIFT;
          end else if (is_shift) begin
            result_d  = opa;   // zero shift passes the value through
            illegal_d = 1'b0;
          end else begin
            result_d  = alu_eval(alu_op, opa, opb);
            illegal_d = 1'b0;
          end
        end
      end
      S_SHIFT: begin
        shreg_d = shifted;
        rem_d   = rem_q - step;
        if (rem_q <= STEP5) begin
          result_d  = shifted;
          illegal_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (OUT_READY) begin
          state_d   = S_IDLE;
          result_d  = '0;
          illegal_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
      shreg_q   <= '0;
      rem_q     <= '0;
      shop_q    <= ALU_SLL;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      shreg_q   <= shreg_d;
      rem_q     <= rem_d;
      shop_q    <= shop_d;
    end
  end

  assign IN_READY  = (state_q == S_IDLE);
  assign BUSY      = (state_q != S_IDLE);
  assign OUT_VALID = (state_q == S_DONE);
  assign RESULT    = result_q;
  assign ILLEGAL   = illegal_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Bench for alu_exec_sequencer: two instances (SHIFT_STEP=1 and 4) share stimulus,
// each checked against a behavioural model of the RV32I rules.
module tb_alu_exec_sequencer;

  localparam logic [6:0] T_OPIMM = 7'b0010011;
  localparam logic [6:0] T_OP    = 7'b0110011;
  localparam logic [6:0] T_LOAD  = 7'b0000011;
  localparam logic [6:0] T_STORE = 7'b0100011;
  localparam logic [6:0] T_LUI   = 7'b0110111;
  localparam logic [6:0] T_AUIPC = 7'b0010111;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic [6:0]  OPCODE = '0;
  logic [2:0]  FUNCT3 = '0;
  logic        FUNCT7_5 = 1'b0;
  logic [31:0] RS1_DATA = '0, RS2_DATA = '0, PC = '0;
  logic [11:0] IMM12 = '0;
  logic [19:0] U_IMM20 = '0;
  logic        OUT_READY = 1'b0;

  logic        in_ready1, out_valid1, illegal1, busy1;
  logic        in_ready4, out_valid4, illegal4, busy4;
  logic [31:0] result1, result4;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res;
  logic        last_ill;

  always #5 CLK = ~CLK;

  alu_exec_sequencer #(.SHIFT_STEP(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(in_ready1),
    .OPCODE(OPCODE), .FUNCT3(FUNCT3), .FUNCT7_5(FUNCT7_5),
    .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA), .PC(PC), .IMM12(IMM12), .U_IMM20(U_IMM20),
    .OUT_VALID(out_valid1), .OUT_READY(OUT_READY), .RESULT(result1),
    .ILLEGAL(illegal1), .BUSY(busy1)
  );

  alu_exec_sequencer #(.SHIFT_STEP(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(in_ready4),
    .OPCODE(OPCODE), .FUNCT3(FUNCT3), .FUNCT7_5(FUNCT7_5),
    .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA), .PC(PC), .IMM12(IMM12), .U_IMM20(U_IMM20),
    .OUT_VALID(out_valid4), .OUT_READY(OUT_READY), .RESULT(result4),
    .ILLEGAL(illegal4), .BUSY(busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: RV32I semantics in plain arithmetic; latency from shamt and step size.
  function automatic void model(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] pc, input logic [11:0] imm,
                                input logic [19:0] u, output logic [31:0] res,
                                output logic ill, output int lat1, output int lat4);
    logic [31:0] b;
    int sh;
    bit shift_op;
    res = '0; ill = 1'b0; shift_op = 0; sh = 0;
    b = {{20{imm[11]}}, imm};
    if (opc == T_LOAD || opc == T_STORE) res = rs1 + b;
    else if (opc == T_LUI) res = {u, 12'h000};
    else if (opc == T_AUIPC) res = pc + {u, 12'h000};
    else if (opc == T_OPIMM || opc == T_OP) begin
      if (opc == T_OP) b = rs2;
      sh = int'(b[4:0]);
      case (f3)
        3'b000: res = (opc == T_OP && f7) ? rs1 - b : rs1 + b;
        3'b010: res = ($signed(rs1) < $signed(b)) ? 32'd1 : 32'd0;
        3'b011: res = (rs1 < b) ? 32'd1 : 32'd0;
        3'b100: res = rs1 ^ b;
        3'b110: res = rs1 | b;
        3'b111: res = rs1 & b;
        3'b001: begin shift_op = 1; res = rs1 << sh; end
        default: begin
          shift_op = 1;
          res = f7 ? 32'($signed(rs1) >>> sh) : rs1 >> sh;
        end
      endcase
    end else ill = 1'b1;
    lat1 = (shift_op && sh != 0) ? 1 + sh : 1;
    lat4 = (shift_op && sh != 0) ? 1 + (sh + 3) / 4 : 1;
  endfunction

  task automatic run_txn(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] pc,
                         input logic [11:0] imm, input logic [19:0] u, input int hold);
    logic [31:0] er;
    logic ei;
    int el1, el4, l1, l4, cyc;
    model(opc, f3, f7, rs1, rs2, pc, imm, u, er, ei, el1, el4);
    @(negedge CLK);
    OPCODE = opc; FUNCT3 = f3; FUNCT7_5 = f7; RS1_DATA = rs1; RS2_DATA = rs2;
    PC = pc; IMM12 = imm; U_IMM20 = u; IN_VALID = 1'b1;
    check("in_ready1_idle", 32'(in_ready1), 32'd1);
    check("in_ready4_idle", 32'(in_ready4), 32'd1);
    @(posedge CLK); #1;
    // Keep IN_VALID high with junk fields: must be ignored until back in IDLE
    OPCODE = 7'($urandom); FUNCT3 = 3'($urandom); FUNCT7_5 = 1'($urandom);
    RS1_DATA = $urandom; RS2_DATA = $urandom; PC = $urandom;
    IMM12 = 12'($urandom); U_IMM20 = 20'($urandom);
    l1 = 0; l4 = 0; cyc = 1;
    forever begin
      if (l1 == 0 && out_valid1) l1 = cyc;
      if (l4 == 0 && out_valid4) l4 = cyc;
      if ((l1 != 0 && l4 != 0) || cyc >= 60) break;
      @(posedge CLK); #1; cyc++;
    end
    check("latency_step1", 32'(l1), 32'(el1));
    check("latency_step4", 32'(l4), 32'(el4));
    check("result_step1", result1, er);
    check("result_step4", result4, er);
    check("illegal_step1", 32'(illegal1), 32'(ei));
    check("illegal_step4", 32'(illegal4), 32'(ei));
    check("busy_done", 32'({busy1, busy4}), 32'd3);
    last_res = result1;
    last_ill = illegal1;
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK); #1;
      check("held_result", result1, er);
      check("held_out_valid", 32'({out_valid1, out_valid4}), 32'd3);
      check("held_in_ready", 32'({in_ready1, in_ready4}), 32'd0);
    end
    @(negedge CLK);
    OUT_READY = 1'b1;     // IN_VALID still high in DONE: no accept this edge
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    IN_VALID = 1'b0;
    check("release_out_valid", 32'({out_valid1, out_valid4}), 32'd0);
    check("release_in_ready", 32'({in_ready1, in_ready4}), 32'd3);
    check("release_result1", result1, 32'd0);
    check("release_result4", result4, 32'd0);
    check("release_illegal", 32'({illegal1, illegal4}), 32'd0);
  endtask

  initial begin
    logic [6:0] opc;
    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_in_ready", 32'({in_ready1, in_ready4}), 32'd3);
    check("rst_out_valid", 32'({out_valid1, out_valid4}), 32'd0);
    check("rst_result", result1 | result4, 32'd0);
    check("rst_illegal_busy", 32'({illegal1, illegal4, busy1, busy4}), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // ADDI 5 + (-1)
    run_txn(T_OPIMM, 3'b000, 1'b0, 32'd5, 32'd0, 32'd0, 12'hFFF, 20'd0, 0);
    check("addi_const", last_res, 32'd4);
    // SUB vs ADDI with the same funct7[5]
    run_txn(T_OP, 3'b000, 1'b1, 32'd10, 32'd3, 32'd0, 12'd0, 20'd0, 0);
    check("sub_const", last_res, 32'd7);
    run_txn(T_OPIMM, 3'b000, 1'b1, 32'd10, 32'd0, 32'd0, 12'd3, 20'd0, 0);
    check("addi_f7_const", last_res, 32'd13);
    // SRAI by 4, shamt 0, SLLI by 31
    run_txn(T_OPIMM, 3'b101, 1'b1, 32'h80000000, 32'd0, 32'd0, 12'd4, 20'd0, 0);
    check("srai_const", last_res, 32'hF8000000);
    run_txn(T_OPIMM, 3'b101, 1'b1, 32'h80000000, 32'd0, 32'd0, 12'd0, 20'd0, 0);
    check("srai0_const", last_res, 32'h80000000);
    run_txn(T_OPIMM, 3'b001, 1'b0, 32'd1, 32'd0, 32'd0, 12'd31, 20'd0, 0);
    check("slli31_const", last_res, 32'h80000000);
    // LUI, AUIPC, SLTU
    run_txn(T_LUI, 3'b000, 1'b0, 32'hDEAD, 32'd0, 32'h44, 12'd0, 20'h12345, 0);
    check("lui_const", last_res, 32'h12345000);
    run_txn(T_AUIPC, 3'b000, 1'b0, 32'd0, 32'd0, 32'h100, 12'd0, 20'h1, 0);
    check("auipc_const", last_res, 32'h1100);
    run_txn(T_OP, 3'b011, 1'b0, 32'd1, 32'hFFFFFFFF, 32'd0, 12'd0, 20'd0, 0);
    check("sltu_const", last_res, 32'd1);
    // Backpressure: writeback stalls 5 cycles
    run_txn(T_OP, 3'b101, 1'b0, 32'hF0F0F0F0, 32'd8, 32'd0, 12'd0, 20'd0, 5);
    check("srl_held_const", last_res, 32'h00F0F0F0);
    // Unsupported opcode
    run_txn(7'b1111111, 3'b000, 1'b0, 32'd9, 32'd9, 32'd0, 12'd1, 20'd1, 1);
    check("illegal_flag", 32'(last_ill), 32'd1);
    check("illegal_result", last_res, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 7))
        0, 1: opc = T_OPIMM;
        2, 3: opc = T_OP;
        4: opc = T_LOAD;
        5: opc = T_STORE;
        6: opc = $urandom_range(0, 1) ? T_LUI : T_AUIPC;
        default: opc = 7'($urandom);
      endcase
      run_txn(opc, 3'($urandom), 1'($urandom), $urandom,
              $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40)),
              $urandom, 12'($urandom), 20'($urandom), $urandom_range(0, 2));
    end

    // Reset in the middle of a long shift aborts it without output
    @(negedge CLK);
    OPCODE = T_OPIMM; FUNCT3 = 3'b001; FUNCT7_5 = 1'b0; RS1_DATA = 32'h3;
    IMM12 = 12'd20; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("mid_shift_busy", 32'({busy1, busy4}), 32'd3);
    RST = 1'b1;
    #1;
    check("abort_out_valid", 32'({out_valid1, out_valid4}), 32'd0);
    check("abort_in_ready", 32'({in_ready1, in_ready4}), 32'd3);
    check("abort_result", result1 | result4, 32'd0);
    check("abort_busy", 32'({busy1, busy4}), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (25) begin
      @(posedge CLK); #1;
      check("abort_no_output", 32'({out_valid1, out_valid4}), 32'd0);
    end
    run_txn(T_OP, 3'b111, 1'b0, 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 12'd0, 20'd0, 0);
    check("post_reset_and", last_res, 32'h0F000F00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
